// File: rtl/mips32_ifetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// branch redirect input, and the valid/ready instruction stream to ID.
interface mips32_ifetch_queue_if #(
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic [31:0]       id_ir;
    logic [31:0]       id_npc;
    logic              id_ready;
    logic              halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output id_valid, id_ir, id_npc,
        input  id_ready,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  id_valid, id_ir, id_npc,
        output id_ready,
        input  halted
    );
endinterface

// File: rtl/mips32_ifetch_queue.sv
// MIPS32 instruction fetch with a credit-gated prefetch FIFO, in-order
// response address tracking, redirect flush with stale-response dropping, and HLT stop.
module mips32_ifetch_queue #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 4,
    parameter int MAX_OUT  = 2,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mips32_ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [OW-1:0]     out_cnt_q, out_cnt_d;
    logic [OW-1:0]     drop_cnt_q, drop_cnt_d;
    logic              halted_q, halted_d;
    logic [QW-1:0]     aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;

    logic [31:0]       ir_mem  [DEPTH];
    logic [31:0]       npc_mem [DEPTH];
    logic [ADDR_W-1:0] aq_mem  [MAX_OUT];

    logic              req, grant, rsp, push, pop;
    logic [ADDR_W-1:0] rsp_addr;
    logic [31:0]       rsp_npc;

    function automatic logic [QW-1:0] aq_next(input logic [QW-1:0] p);
        return (32'(p) == 32'(MAX_OUT - 1)) ? '0 : p + QW'(1);
    endfunction

    function automatic logic is_hlt(input logic [5:0] opcode);
        return opcode == 6'b111111;
    endfunction

    // Credit rule: every outstanding request owns a free FIFO slot, so responses never stall.
    assign req      = !rst && !halted_q && !bus.redirect
                      && (out_cnt_q < OW'(MAX_OUT))
                      && ((32'(count_q) + 32'(out_cnt_q)) < 32'(DEPTH));
    assign grant    = req && bus.imem_gnt;
    assign rsp      = bus.imem_rvalid && (out_cnt_q != '0);
    assign rsp_addr = aq_mem[aq_rd_q];
    assign rsp_npc  = {{(32-ADDR_W){1'b0}}, rsp_addr} + 32'd1;
    assign push     = rsp && (drop_cnt_q == '0) && !halted_q && !bus.redirect;
    assign pop      = (count_q != '0) && bus.id_ready && !bus.redirect;

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = (count_q != '0);
    assign bus.id_ir     = (count_q != '0) ? ir_mem[rd_ptr_q]  : '0;
    assign bus.id_npc    = (count_q != '0) ? npc_mem[rd_ptr_q] : '0;
    assign bus.halted    = halted_q;

    always_comb begin
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        halted_d   = halted_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;

        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            halted_d   = 1'b0;
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_d = rsp ? out_cnt_q - OW'(1) : out_cnt_q;
        end else begin
            if (grant) pc_d = pc_q + ADDR_W'(1);
            if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
            if (push && is_hlt(bus.imem_rdata[31:26])) halted_d = 1'b1;
        end

        case ({grant, rsp})
            2'b10:   out_cnt_d = out_cnt_q + OW'(1);
            2'b01:   out_cnt_d = out_cnt_q - OW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
        if (grant) aq_wr_d = aq_next(aq_wr_q);
        if (rsp)   aq_rd_d = aq_next(aq_rd_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= ADDR_W'(RESET_PC);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            halted_q   <= 1'b0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            halted_q   <= halted_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr_q]  <= bus.imem_rdata;
            npc_mem[wr_ptr_q] <= rsp_npc;
        end
        if (grant) aq_mem[aq_wr_q] <= pc_q;
    end
endmodule

// File: tb/tb_mips32_ifetch_queue.sv
// Bench for mips32_ifetch_queue: behavioural memory plus a queue-based model of
// the fetch unit, directed scenarios followed by a randomized soak.
module tb_mips32_ifetch_queue;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips32_ifetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

    mips32_ifetch_queue #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed { logic [ADDR_W-1:0] addr; logic stale; } out_t;
    typedef struct packed { logic [31:0] ir; logic [31:0] npc; } ent_t;
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] due; } pend_t;

    logic [31:0]       mem [1024];
    pend_t             mp[$];
    out_t              m_out[$];
    ent_t              m_fifo[$];
    logic [ADDR_W-1:0] m_pc;
    logic              m_halted;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_pct, rdy_pct, lat_min, lat_max;
    logic              in_redirect;
    logic [ADDR_W-1:0] in_rpc;

    logic              obs_req, obs_gnt, obs_rv, obs_valid, obs_halt;
    logic [ADDR_W-1:0] obs_addr;
    logic [31:0]       obs_ir, obs_npc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        rv, exp_req, hset;
        logic [31:0] rd, due;
        out_t        o;
        rv = (mp.size() > 0) && (mp[0].due <= 32'(cyc));
        rd = rv ? mem[mp[0].addr] : $urandom();
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
        bus.id_ready    = ($urandom_range(99) < rdy_pct);
        bus.redirect    = in_redirect;
        bus.redirect_pc = in_rpc;
        #1;
        obs_req = bus.imem_req;  obs_addr = bus.imem_addr; obs_gnt = bus.imem_gnt;
        obs_rv = rv;             obs_valid = bus.id_valid; obs_ir = bus.id_ir;
        obs_npc = bus.id_npc;    obs_halt = bus.halted;

        exp_req = !rst && !m_halted && !in_redirect && (m_out.size() < MAX_OUT)
                  && (m_fifo.size() + m_out.size() < DEPTH);
        chk("imem_req", 32'(obs_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", 32'(obs_addr), 32'(m_pc));
        chk("id_valid", 32'(obs_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            chk("id_ir", obs_ir, m_fifo[0].ir);
            chk("id_npc", obs_npc, m_fifo[0].npc);
        end
        chk("halted", 32'(obs_halt), 32'(m_halted));

        // Memory: accepts whatever the DUT actually requested, answers in order.
        if (rst) mp.delete();
        else begin
            if (rv) void'(mp.pop_front());
            if (obs_req && obs_gnt) begin
                due = 32'(cyc + int'($urandom_range(lat_max, lat_min)));
                if (mp.size() > 0 && due <= mp[$].due) due = mp[$].due + 1;
                mp.push_back('{addr: obs_addr, due: due});
            end
        end

        // Reference model of the fetch unit.
        if (rst) begin
            m_out.delete(); m_fifo.delete(); m_pc = '0; m_halted = 1'b0;
        end else if (in_redirect) begin
            if (rv && m_out.size() > 0) void'(m_out.pop_front());
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_fifo.delete();
            m_pc = in_rpc;
            m_halted = 1'b0;
        end else begin
            hset = 1'b0;
            if (m_fifo.size() > 0 && bus.id_ready) void'(m_fifo.pop_front());
            if (rv && m_out.size() > 0) begin
                o = m_out.pop_front();
                if (!o.stale && !m_halted) begin
                    m_fifo.push_back('{ir: rd, npc: 32'(o.addr) + 32'd1});
                    if (rd[31:26] == 6'b111111) hset = 1'b1;
                end
            end
            if (exp_req && obs_gnt) begin
                m_out.push_back('{addr: m_pc, stale: 1'b0});
                m_pc = m_pc + 1'b1;
            end
            if (hset) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        in_redirect = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_id_ir", obs_ir, 32'h0);
        chk("rst_imem_addr", 32'(obs_addr), 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        tick();
        while (!obs_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int first, nxt, ngr, max_addr, nga;
        logic saw_hlt;
        logic [ADDR_W-1:0] ga [2];
        for (int k = 0; k < 1024; k++) mem[k] = 32'(k);
        rst = 1'b1; in_redirect = 1'b0; in_rpc = '0;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with a 1-cycle memory
        do_reset();
        first = 0; nxt = 0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            if (obs_valid && first == 0) first = n;
            if (n >= 3) chk("stream_valid", 32'(obs_valid), 32'h1);
            if (obs_valid) begin
                chk("stream_ir", obs_ir, 32'(nxt));
                chk("stream_npc", obs_npc, 32'(nxt + 1));
                nxt++;
            end
        end
        chk("first_fetch_cycle", 32'(first), 32'd3);

        // Back-pressure fills exactly DEPTH entries
        do_reset();
        rdy_pct = 0; ngr = 0;
        repeat (12) begin
            tick();
            if (obs_req && obs_gnt) ngr++;
        end
        chk("stall_grants", 32'(ngr), 32'(DEPTH));
        chk("stall_req_low", 32'(obs_req), 32'h0);
        rdy_pct = 100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_valid", 32'(obs_valid), 32'h1);
            chk("drain_ir", obs_ir, 32'(i));
        end

        // Redirect with two stale responses in flight (3-cycle memory)
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (2) tick();
        in_redirect = 1'b1; in_rpc = 10'h100;
        tick();
        in_redirect = 1'b0;
        wait_valid(30);
        chk("redir_valid", 32'(obs_valid), 32'h1);
        chk("redir_ir", obs_ir, 32'h100);
        chk("redir_npc", obs_npc, 32'h101);

        // Redirect coinciding with a response and a pop
        lat_min = 2; lat_max = 2;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            if (n >= 6 && mp.size() > 0 && mp[0].due <= 32'(cyc) && m_fifo.size() > 0) break;
            tick();
        end
        in_redirect = 1'b1; in_rpc = 10'h020;
        tick();
        in_redirect = 1'b0;
        chk("redir_rsp_same_cycle", 32'(obs_rv), 32'h1);
        tick();
        chk("redir_fifo_empty", 32'(obs_valid), 32'h0);
        wait_valid(30);
        chk("redir2_ir", obs_ir, 32'h020);

        // HLT stops fetch, a redirect restarts it
        lat_min = 1; lat_max = 1;
        mem[5] = 32'hFC00_0000;
        do_reset();
        max_addr = 0; saw_hlt = 1'b0;
        repeat (20) begin
            tick();
            if (obs_req && obs_gnt && int'(obs_addr) > max_addr) max_addr = int'(obs_addr);
            if (obs_valid && obs_ir == 32'hFC00_0000) saw_hlt = 1'b1;
        end
        chk("hlt_max_addr", 32'(max_addr), 32'd6);
        chk("hlt_delivered", 32'(saw_hlt), 32'h1);
        chk("hlt_halted", 32'(obs_halt), 32'h1);
        chk("hlt_req_low", 32'(obs_req), 32'h0);
        in_redirect = 1'b1; in_rpc = '0;
        tick();
        in_redirect = 1'b0;
        tick();
        chk("hlt_cleared", 32'(obs_halt), 32'h0);
        chk("hlt_resume_req", 32'(obs_req), 32'h1);
        repeat (10) tick();
        mem[5] = 32'd5;

        // PC wrap at the top of the address space
        do_reset();
        in_redirect = 1'b1; in_rpc = 10'h3FF;
        tick();
        in_redirect = 1'b0;
        nga = 0; first = 0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (obs_req && obs_gnt && nga < 2) begin
                ga[nga] = obs_addr;
                nga++;
            end
            if (obs_valid && first == 0) begin
                first = 1;
                chk("wrap_ir", obs_ir, 32'h3FF);
                chk("wrap_npc", obs_npc, 32'h400);
            end
        end
        chk("wrap_grants", 32'(nga), 32'd2);
        chk("wrap_addr0", 32'(ga[0]), 32'h3FF);
        chk("wrap_addr1", 32'(ga[1]), 32'h000);
        chk("wrap_seen", 32'(first), 32'd1);

        // Randomized soak against the model
        for (int k = 0; k < 1024; k++)
            mem[k] = ($urandom_range(15) == 0) ? {6'b111111, 26'($urandom())}
                                                : {6'($urandom_range(62)), 26'($urandom())};
        gnt_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            in_redirect = ($urandom_range(99) < 4);
            in_rpc = ADDR_W'($urandom());
            rst = ($urandom_range(999) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
